morph_window_ctrl: RTL and testbench

Scan sequencer for the 3x3 morphology (erosion/dilation) engine. Accepts a raster pixel stream and holds the two previous image rows in internal line buffers. Presents three vertically aligned row taps plus a qualified valid strobe to the engine, flushes the engine pipeline at end of frame, and produces the output-valid and border flags that mark which engine results are real pixels.

---
 rtl/morph_window_ctrl.sv | 157 +++++++++++++++
 tb/tb_morph_window_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_window_ctrl.sv
// Scan sequencer for the 3x3 morphology engine: two line buffers build a vertical
// 3-pixel window, strobe it into the engine, flush at end of frame and tag interior results.
module morph_window_ctrl #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 320,
    parameter int PIC_HEIGHT = 240,
    parameter int ENG_LAT    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [WIDTH-1:0] s_data,
    output logic [WIDTH-1:0] tap0,
    output logic [WIDTH-1:0] tap1,
    output logic [WIDTH-1:0] tap2,
    output logic             tap_valid,
    output logic             m_valid,
    output logic             frame_done,
    output logic             busy,
    output logic             err_sof
);

    localparam int COL_W = $clog2(PIC_WIDTH);
    localparam int ROW_W = $clog2(PIC_HEIGHT);
    localparam int FL_W  = $clog2(ENG_LAT + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PIC_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PIC_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(ENG_LAT);
    localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [FL_W-1:0]    flush_cnt;
    logic               tag_cur;
    logic [ENG_LAT-1:0] tag_pipe;

    logic [WIDTH-1:0] lb0 [PIC_WIDTH];
    logic [WIDTH-1:0] lb1 [PIC_WIDTH];

    logic             accept;
    logic             take;
    logic             restart;
    logic [COL_W-1:0] wcol;

    assign accept  = s_valid & s_ready;
    assign take    = accept & ((state == RUN) | ((state == IDLE) & s_sof));
    assign restart = accept & (state == RUN) & s_sof;
    assign wcol    = s_sof ? '0 : col;
    assign busy    = (state != IDLE);

    // Buffers are read before write so lb0 receives the row that lb1 held.
    always_ff @(posedge clk) begin
        if (take) begin
            lb1[wcol] <= s_data;
            lb0[wcol] <= lb1[wcol];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            flush_cnt  <= '0;
            tag_cur    <= 1'b0;
            tag_pipe   <= '0;
            tap0       <= '0;
            tap1       <= '0;
            tap2       <= '0;
            tap_valid  <= 1'b0;
            m_valid    <= 1'b0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            s_ready    <= 1'b0;
        end else begin
            tap_valid  <= 1'b0;
            m_valid    <= 1'b0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            s_ready    <= 1'b1;

            // Tags advance only with engine strobes so they stay aligned with its results.
            if (tap_valid) begin
                tag_pipe <= (tag_pipe << 1) | ENG_LAT'(tag_cur);
                m_valid  <= tag_pipe[ENG_LAT-1];
            end

            if (take) begin
                tap2 <= s_data;
                tap1 <= lb1[wcol];
                tap0 <= lb0[wcol];
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        state <= RUN;
                        col   <= COL_ONE;
                        row   <= '0;
                    end
                end
                RUN: begin
                    if (restart) begin
                        err_sof  <= 1'b1;
                        tag_pipe <= '0;
                        m_valid  <= 1'b0;
                        col      <= COL_ONE;
                        row      <= '0;
                    end else if (take) begin
                        tap_valid <= (row >= ROW_TWO);
                        tag_cur   <= (col >= COL_TWO);
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row       <= '0;
                                state     <= FLUSH;
                                s_ready   <= 1'b0;
                                flush_cnt <= '0;
                            end else begin
                                row <= row + ROW_ONE;
                            end
                        end else begin
                            col <= col + COL_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end else begin
                        s_ready   <= 1'b0;
                        tap_valid <= 1'b1;
                        tag_cur   <= 1'b0;
                        flush_cnt <= flush_cnt + FL_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morph_window_ctrl.sv
// Self-checking bench for morph_window_ctrl: an event-schedule model of the frame protocol
// is compared against the DUT every cycle, plus literal expectations for counts and taps.
module tb_morph_window_ctrl;

    localparam int W    = 8;
    localparam int H    = 5;
    localparam int L    = 3;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_sof = 1'b0;
    logic [23:0] s_data = '0;
    logic [23:0] tap0;
    logic [23:0] tap1;
    logic [23:0] tap2;
    logic        tap_valid;
    logic        m_valid;
    logic        frame_done;
    logic        busy;
    logic        err_sof;

    int checks = 0;
    int failures = 0;

    morph_window_ctrl #(
        .WIDTH(24), .PIC_WIDTH(W), .PIC_HEIGHT(H), .ENG_LAT(L)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_data(s_data), .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap_valid(tap_valid),
        .m_valid(m_valid), .frame_done(frame_done), .busy(busy), .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    // Model state: per-cycle schedules of expected strobes and pulses.
    bit          sch_tv  [MAXC];
    bit          sch_mv  [MAXC];
    bit          sch_fd  [MAXC];
    bit          sch_err [MAXC];
    bit          tagq [$];
    int          cyc = 0;
    int          mode = 0;
    int          mrow = 0;
    int          mcol = 0;
    int          fl_end = 0;
    int          r2c3_cyc = -1;
    bit          m_acc;
    bit          acc_last = 1'b0;
    bit          e_rdy = 1'b0;
    bit          e_lo_known = 1'b1;
    logic [23:0] e_tap0 = '0;
    logic [23:0] e_tap1 = '0;
    logic [23:0] e_tap2 = '0;

    int n_tv = 0, n_mv = 0, n_fd = 0, n_err = 0;
    int b_tv, b_mv, b_fd, b_err;
    logic [23:0] cap0, cap1, cap2;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic strobe(input int t, input bit tag);
        bit old;
        if (t + 1 < MAXC) begin
            sch_tv[t] = 1'b1;
            tagq.push_back(tag);
            old = tagq.pop_front();
            if (old) sch_mv[t+1] = 1'b1;
        end
    endtask

    task automatic clearModel();
        sch_tv  = '{default: 1'b0};
        sch_mv  = '{default: 1'b0};
        sch_fd  = '{default: 1'b0};
        sch_err = '{default: 1'b0};
        tagq.delete();
        repeat (L) tagq.push_back(1'b0);
        mode = 0; mrow = 0; mcol = 0;
        e_tap0 = '0; e_tap1 = '0; e_tap2 = '0;
        e_lo_known = 1'b1;
        e_rdy = 1'b0;
        acc_last = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clearModel();
        end else begin
            m_acc = s_valid && e_rdy;
            acc_last = m_acc;
            cyc++;
            if (m_acc && (mode != 0 || s_sof)) begin
                if (mode == 1 && s_sof) begin
                    sch_err[cyc] = 1'b1;
                    sch_mv[cyc] = 1'b0;
                    tagq.delete();
                    repeat (L) tagq.push_back(1'b0);
                end
                if (s_sof) begin
                    mrow = 0;
                    mcol = 0;
                end
                mode = 1;
                e_tap2 = s_data;
                e_tap1 = 24'((mrow - 1) * 16 + mcol);
                e_tap0 = 24'((mrow - 2) * 16 + mcol);
                e_lo_known = (mrow >= 2);
                if (mrow == 2 && mcol == 3) r2c3_cyc = cyc;
                if (mrow >= 2) strobe(cyc, mcol >= 2);
                if (mrow == H - 1 && mcol == W - 1) begin
                    mode = 2;
                    fl_end = cyc + L;
                    for (int k = 1; k <= L; k++) strobe(cyc + k, 1'b0);
                    sch_fd[cyc + L + 1] = 1'b1;
                end else if (mcol == W - 1) begin
                    mcol = 0;
                    mrow++;
                end else begin
                    mcol++;
                end
            end
            if (mode == 2 && cyc == fl_end + 1) mode = 0;
            e_rdy = (mode != 2);
        end
    end

    // Per-cycle comparison against the model, sampled just after the clock edge.
    always @(posedge clk) begin
        #1;
        checkOutput("tap_valid", tap_valid, sch_tv[cyc]);
        checkOutput("m_valid", m_valid, sch_mv[cyc]);
        checkOutput("frame_done", frame_done, sch_fd[cyc]);
        checkOutput("err_sof", err_sof, sch_err[cyc]);
        checkOutput("s_ready", s_ready, e_rdy);
        checkOutput("busy", busy, mode != 0);
        checkOutput("tap2", tap2, e_tap2);
        if (e_lo_known) begin
            checkOutput("tap1", tap1, e_tap1);
            checkOutput("tap0", tap0, e_tap0);
        end
        if (!rst) begin
            n_tv  += int'(tap_valid);
            n_mv  += int'(m_valid);
            n_fd  += int'(frame_done);
            n_err += int'(err_sof);
        end
        if (cyc == r2c3_cyc) begin
            cap0 = tap0; cap1 = tap1; cap2 = tap2;
        end
    end

    task automatic applyStimulus(input int r, input int c, input bit sof, input int gap);
        repeat (gap) begin
            s_valid = 1'b0;
            s_sof = 1'($urandom_range(0, 1));
            s_data = 24'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_sof = sof;
        s_data = 24'(r * 16 + c);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (acc_last) begin
                s_valid = 1'b0;
                s_sof = 1'b0;
                return;
            end
        end
        checkOutput("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_sof = 1'b0;
    endtask

    task automatic sendRange(input int first, input int last, input int maxgap);
        for (int i = first; i < last; i++)
            applyStimulus(i / W, i % W, i == 0, int'($urandom_range(0, maxgap)));
    endtask

    task automatic snap();
        b_tv = n_tv; b_mv = n_mv; b_fd = n_fd; b_err = n_err;
    endtask

    task automatic settle();
        repeat (L + 5) @(negedge clk);
    endtask

    task automatic checkFrame(input string name, input int tv, input int mv, input int fd);
        checkOutput({name, "_tv_count"}, n_tv - b_tv, tv);
        checkOutput({name, "_mv_count"}, n_mv - b_mv, mv);
        checkOutput({name, "_fd_count"}, n_fd - b_fd, fd);
    endtask

    task automatic checkCapture(input string name);
        checkOutput({name, "_r2c3_tap0"}, cap0, 24'h03);
        checkOutput({name, "_r2c3_tap1"}, cap1, 24'h13);
        checkOutput({name, "_r2c3_tap2"}, cap2, 24'h23);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset with noise on the inputs.
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = 24'($urandom);
            @(negedge clk);
            checkOutput("rst_s_ready", s_ready, 1'b0);
            checkOutput("rst_tap_valid", tap_valid, 1'b0);
            checkOutput("rst_tap2", tap2, 24'h0);
            checkOutput("rst_busy", busy, 1'b0);
        end
        s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_s_ready", s_ready, 1'b1);

        // Continuous full frame; rows 0-1 must not strobe.
        snap();
        cap0 = '0; cap1 = '0; cap2 = '0;
        sendRange(0, 2 * W, 0);
        @(negedge clk);
        checkOutput("fill_rows_tv", n_tv - b_tv, 0);
        sendRange(2 * W, W * H, 0);
        settle();
        checkFrame("full", 27, 18, 1);
        checkCapture("full");

        // Random gaps between pixels.
        snap();
        cap0 = '0; cap1 = '0; cap2 = '0;
        sendRange(0, W * H, 4);
        settle();
        checkFrame("gaps", 27, 18, 1);
        checkCapture("gaps");

        // Mid-frame start-of-frame at row 3 col 5 restarts the frame.
        snap();
        sendRange(0, 3 * W + 5, 1);
        checkOutput("abort_no_fd", n_fd - b_fd, 0);
        snap();
        sendRange(0, W * H, 2);
        settle();
        checkOutput("restart_err_count", n_err - b_err, 1);
        checkFrame("restart", 27, 18, 1);

        // Back-to-back frames, second start-of-frame stalls through the flush.
        snap();
        sendRange(0, W * H, 0);
        sendRange(0, W * H, 0);
        settle();
        checkFrame("b2b", 54, 36, 2);
        checkOutput("b2b_err_count", n_err - b_err, 0);

        // Reset in the middle of row 2.
        sendRange(0, 2 * W + 4, 0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tap_valid", tap_valid, 1'b0);
        checkOutput("midrst_tap2", tap2, 24'h0);
        checkOutput("midrst_tap1", tap1, 24'h0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_s_ready", s_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 1'b0, 0);
        @(negedge clk);
        checkOutput("drop_busy", busy, 1'b0);
        snap();
        sendRange(0, W * H, 1);
        settle();
        checkFrame("postrst", 27, 18, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
